mem_port_arbiter: RTL

//  Shares the single instruction/data memory port (ROM today, RAM later) between the core's

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_arb_grant.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory-port arbiter.
//   mem_req_t   : one latched memory request (address, write flag, byte strobes, write data)
//                 at the default bus widths.
//   owner_e     : which requester owns the outstanding transaction.
//   arb_state_e : arbiter FSM state encoding (also visible on the debug state port).
package mem_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_STRB_W = DEFAULT_DATA_W / 8;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic                      we;
    logic [DEFAULT_STRB_W-1:0] wstrb;
    logic [DEFAULT_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision for the shared memory port: data side has fixed priority, with a
// starvation counter that forces a fetch grant once fetch has watched STARVE_LIMIT
// consecutive data grants go by.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         arbiter is idle and may grant this cycle
//   if_valid   fetch request pending
//   d_valid    load/store request pending
//   grant_if   fetch granted this cycle (combinational)
//   grant_d    load/store granted this cycle (combinational)
module mem_arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_if;

  // Fetch is forced only while it is actually waiting and the budget is spent.
  assign force_if = if_valid && (starve_cnt == LIMIT);

  always_comb begin
    grant_if = en && if_valid && (force_if || !d_valid);
    grant_d  = en && d_valid && !force_if;
  end

  // The counter only moves while the arbiter is idle (the grant cycle). A fetch
  // grant or an idle cycle without a fetch request clears it; a data grant that
  // overtakes a waiting fetch counts up, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (en) begin
      if (!if_valid || grant_if) begin
        starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch requester and the
// load/store requester. One transaction is outstanding at a time:
// IDLE (grant + latch) -> ISSUE (present to memory) -> WAIT (await response) -> IDLE.
//
// Handshake semantics (all request channels): a transfer happens on a rising
// clock edge where valid and ready are both high. The requester holds its
// request fields stable while valid is high and not yet accepted. The
// *_req_ready outputs are combinational from *_req_valid and are only ever high
// in IDLE, never both in one cycle. mem_req_valid is high for the whole ISSUE
// state with the latched fields stable until mem_req_ready. Responses are
// one-cycle pulses with no back-pressure: *_rsp_valid is high for exactly one
// cycle, the cycle after mem_rsp_valid is seen in WAIT.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   if_req_valid/if_req_ready/if_addr fetch request channel
//   if_rsp_valid/if_rdata             fetch response (pulse + held word)
//   d_req_valid/d_req_ready/d_addr/d_we/d_wstrb/d_wdata  load/store request channel
//   d_rsp_valid/d_rdata               load/store response (rdata is 0 for stores)
//   mem_req_valid/mem_req_ready/mem_addr/mem_we/mem_wstrb/mem_wdata  memory request
//   mem_rsp_valid/mem_rdata           memory response
//   dbg_state                         current arbiter state (arb_state_e encoding)
module mem_port_arbiter import mem_pkg::*; #(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);

  arb_state_e state_q;
  arb_state_e state_d;
  owner_e     owner_q;
  logic       grant_en;
  logic       grant_if;
  logic       grant_d;

  // Readies are gated by rst as well, so they read 0 for the whole reset window
  // even though they are combinational from the request valids.
  assign grant_en = (state_q == S_IDLE) && !rst;

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .en       (grant_en),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  assign if_req_ready  = grant_if;
  assign d_req_ready   = grant_d;
  assign mem_req_valid = (state_q == S_ISSUE);
  assign dbg_state     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // mem_rsp_valid outside WAIT is a leftover from a transaction killed by reset
  // and is deliberately not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_if || grant_d) state_d = S_ISSUE;
      S_ISSUE: if (mem_req_ready)       state_d = S_WAIT;
      S_WAIT:  if (mem_rsp_valid)       state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Request register: captured in the grant cycle, held through ISSUE/WAIT and
  // left as-is afterwards. Fetches carry no write side-band.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      owner_q   <= OWN_IF;
    end else if (grant_d) begin
      mem_addr  <= d_addr;
      mem_we    <= d_we;
      mem_wstrb <= d_wstrb;
      mem_wdata <= d_wdata;
      owner_q   <= OWN_D;
    end else if (grant_if) begin
      mem_addr  <= if_addr;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      owner_q   <= OWN_IF;
    end
  end

  // Response register: only the owner's rdata is updated; the other side keeps
  // its last word. Store completions return 0 rather than whatever the memory
  // drives on its read bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      d_rsp_valid  <= 1'b0;
      d_rdata      <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      if ((state_q == S_WAIT) && mem_rsp_valid) begin
        if (owner_q == OWN_IF) begin
          if_rsp_valid <= 1'b1;
          if_rdata     <= mem_rdata;
        end else begin
          d_rsp_valid  <= 1'b1;
          d_rdata      <= mem_we ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule
